seq_alu_display: RTL and testbench
==================================

Name: seq_alu_display

Overview:
- Clocked, parametrised successor to the switch-driven mini ALU and display path.
- Accepts a start request carrying two OP_W-bit operands, an opcode and a signed/unsigned mode.
- Computes add, subtract or multiply; multiply is a multi-cycle shift-add.
- Converts the magnitude to BCD with a sequential double-dabble, then drives NUM_DIGITS seven-segment digits.
- Sits between the board switch/button sync logic and the seven-segment pins.

Parameters:
- OP_W, 4: operand width in bits. RES_W = 2*OP_W is derived.
- NUM_DIGITS, 6: number of seven-segment digits. Must satisfy NUM_DIGITS >= (decimal digits of 2^RES_W) + 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op1  in  OP_W  operand 1.
- op2  in  OP_W  operand 2.
- opcode  in  2  00 add, 01 sub, 10 mul, 11 illegal.
- signed_mode  in  1  1 = operands are two's complement.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when result/display update.
- error  out  1  sticky until next accepted start; set by illegal opcode.
- result  out  RES_W+1  signed result, registered.
- displayBits  out  8*NUM_DIGITS  digit i at [8i+7:8i], digit 0 rightmost.

Behaviour:
- Reset: one clock, asynchronous active-high reset.
  - State goes to IDLE.
  - busy=0, done=0, error=0, result=0.
  - Every digit = 0xFF (blank).
- Start acceptance:
  - start=1 in IDLE captures op1, op2, opcode and signed_mode into registers.
  - Inputs changing after capture have no effect.
  - start is ignored in all other states, including DONE.
- Operand extension: operands are sign-extended (signed_mode=1) or zero-extended to RES_W+1 bits.
- Add/sub:
  - Computed in RES_W+1 bits; cannot overflow.
  - An unsigned sub that borrows gives a negative result.
- Mul:
  - Shift-add on operand magnitudes (|−2^(OP_W−1)| fits OP_W bits unsigned).
  - Product sign = sign1 XOR sign2, signed mode only.
  - Result is negated when the product is negative.
- FSM states: IDLE, CALC, CONV, DONE.
  - IDLE -> CALC on an accepted start with opcode != 11.
  - IDLE -> DONE on an accepted start with opcode 11.
  - CALC: 1 cycle for add/sub; OP_W cycles for mul (one partial product per cycle). Then -> CONV.
  - CONV: RES_W cycles of double-dabble on the RES_W-bit magnitude. Then -> DONE.
  - DONE: exactly 1 cycle, then -> IDLE.
- Updates on entering DONE:
  - result, displayBits and error are loaded; done=1 for that cycle only.
- Latency: done is high after 1 + C + RES_W rising edges from the edge that accepted start.
  - C = 1 for add/sub, C = OP_W for mul.
  - Defaults: 10 edges for add/sub, 13 for mul, 1 for illegal opcode.
- Display encoding:
  - Per digit: bit 7 = decimal point, bits 6:0 = segments g..a; active-low; dp always off.
  - 0-9 = C0 F9 A4 B0 99 92 82 F8 80 90; blank = FF; minus = BF; E = 86; r = AF.
  - Leading-zero suppression: digit 0 always shown, higher zero digits above the MS non-zero digit are blank.
  - Negative result: digit NUM_DIGITS-1 = minus.
- Illegal opcode:
  - result = 0, error = 1.
  - Digits 2,1,0 = E,r,r; all other digits blank.
- Display hold: displayBits and result hold their last values until the next DONE.
- Reset mid-operation: aborts immediately to the reset values; no done pulse is produced.

Decomposition:
- Package alu_disp_pkg holds:
  - opcode enum: OP_ADD, OP_SUB, OP_MUL, OP_ILL.
  - state enum.
  - 8-bit segment constants: SEG_DIGIT[0:9], SEG_BLANK, SEG_MINUS, SEG_E, SEG_R.
- One sub-module: bcd_seq_converter.
  - Parametrised on input width and digit count.
  - Ports: clk/rst, load, bin, busy, bcd.
  - Runs the double-dabble over RES_W cycles.
- The top contains the FSM, datapath and segment mapping.

Test Plan:
- Unsigned add, op1=9, op2=7, opcode=00, signed_mode=0 -> done after 10 edges; result=16; digit1=F9, digit0=82, digits 5..2=FF; error=0.
- Signed sub, op1=3, op2=5, opcode=01, signed_mode=1 -> result=-2 (all ones except LSB 0); digit0=A4; digit5=BF; others FF.
- Unsigned mul 15*15 and signed mul (-8)*(-8):
  - 15*15 -> done after 13 edges; result=225; digits 2..0 = A4 A4 92.
  - (-8)*(-8) -> result=64; digits 1..0 = 82 99; no minus.
- Illegal opcode=11 -> done after 1 edge; error=1; digits 2..0 = 86 AF AF; result=0.
  - A following legal start clears error.
- start pulsed again during CALC/CONV -> ignored; the first operation completes with its captured operands.
  - Operand inputs changed mid-operation -> no effect on the result.
- rst asserted during CONV of a mul -> busy=0 and all digits FF immediately (asynchronous); no done pulse.
  - A new start after rst deasserts completes normally.

Source files
------------

// File: rtl/seq_alu_display_pkg.sv
// Shared types and seven-segment constants for the sequential ALU display path.
// Segment bytes are active-low {dp, g..a}.
package alu_disp_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_ILL = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_CONV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        if (d > 4'd9) return SEG_BLANK;
        return SEG_DIGIT[d];
    endfunction

endpackage

// File: rtl/seq_alu_display_bcd_seq_converter.sv
// Sequential double-dabble: load consumes the first input bit, then one bit per
// cycle, so the BCD value is final IN_W cycles after load.
module bcd_seq_converter #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(IN_W + 1);

    logic [IN_W-1:0]     sh;
    logic [CNT_W-1:0]    cnt;
    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            cnt <= '0;
            bcd <= '0;
        end else if (load) begin
            // digits start at zero, so the first step needs no adjust
            bcd <= (4*DIGITS)'(bin[IN_W-1]);
            sh  <= bin << 1;
            cnt <= CNT_W'(IN_W - 1);
        end else if (cnt != '0) begin
            bcd <= {adj[4*DIGITS-2:0], sh[IN_W-1]};
            sh  <= sh << 1;
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/seq_alu_display.sv
// Clocked mini ALU (add/sub/shift-add mul) feeding a sequential BCD converter
// and a registered seven-segment display image.
module seq_alu_display
    import alu_disp_pkg::*;
#(
    parameter int OP_W       = 4,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [OP_W-1:0]         op1,
    input  logic [OP_W-1:0]         op2,
    input  logic [1:0]              opcode,
    input  logic                    signed_mode,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [2*OP_W:0]         result,
    output logic [8*NUM_DIGITS-1:0] displayBits
);

    localparam int RES_W = 2 * OP_W;
    localparam int BCD_N = NUM_DIGITS - 1;
    localparam int IDX_W = (OP_W > 1) ? $clog2(OP_W) : 1;
    localparam logic [8*NUM_DIGITS-1:0] ERR_DISP =
        {{(NUM_DIGITS-3){SEG_BLANK}}, SEG_E, SEG_R, SEG_R};

    state_t              state;
    opcode_t             opc_q;
    logic [OP_W-1:0]     a_q, b_q, mag_a, mag_b;
    logic                sm_q, pneg, neg_q, nz;
    logic [RES_W-1:0]    acc, pp, acc_nx, mag;
    logic [IDX_W-1:0]    idx;
    logic signed [RES_W:0] ext1, ext2, calc_val, res_q;
    logic                calc_last, conv_load, conv_busy;
    logic [4*BCD_N-1:0]  bcd;
    logic [8*NUM_DIGITS-1:0] disp_nx;

    always_comb begin
        ext1  = {{(RES_W+1-OP_W){sm_q & a_q[OP_W-1]}}, a_q};
        ext2  = {{(RES_W+1-OP_W){sm_q & b_q[OP_W-1]}}, b_q};
        // -2^(OP_W-1) negates to itself, which is its correct unsigned magnitude
        mag_a = (sm_q && a_q[OP_W-1]) ? -a_q : a_q;
        mag_b = (sm_q && b_q[OP_W-1]) ? -b_q : b_q;
        pneg  = sm_q & (a_q[OP_W-1] ^ b_q[OP_W-1]);
        pp    = mag_b[idx] ? (RES_W'(mag_a) << idx) : '0;
        acc_nx = acc + pp;
        case (opc_q)
            OP_ADD:  calc_val = ext1 + ext2;
            OP_SUB:  calc_val = ext1 - ext2;
            default: calc_val = pneg ? -{1'b0, acc_nx} : {1'b0, acc_nx};
        endcase
        calc_last = (opc_q != OP_MUL) || (idx == IDX_W'(OP_W - 1));
        mag       = calc_val[RES_W] ? RES_W'(-calc_val) : calc_val[RES_W-1:0];
        conv_load = (state == S_CALC) && calc_last;
    end

    always_comb begin
        disp_nx = '0;
        nz      = 1'b0;
        for (int i = BCD_N - 1; i >= 0; i--) begin
            nz = nz | (bcd[4*i +: 4] != 4'd0);
            disp_nx[8*i +: 8] = (nz || i == 0) ? seg_of(bcd[4*i +: 4]) : SEG_BLANK;
        end
        disp_nx[8*NUM_DIGITS-1 -: 8] = neg_q ? SEG_MINUS : SEG_BLANK;
    end

    bcd_seq_converter #(.IN_W(RES_W), .DIGITS(BCD_N)) u_bcd (
        .clk  (clk),
        .rst  (rst),
        .load (conv_load),
        .bin  (mag),
        .busy (conv_busy),
        .bcd  (bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            opc_q       <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            sm_q        <= 1'b0;
            acc         <= '0;
            idx         <= '0;
            res_q       <= '0;
            neg_q       <= 1'b0;
            error       <= 1'b0;
            result      <= '0;
            displayBits <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    a_q   <= op1;
                    b_q   <= op2;
                    opc_q <= opcode_t'(opcode);
                    sm_q  <= signed_mode;
                    acc   <= '0;
                    idx   <= '0;
                    if (opcode_t'(opcode) == OP_ILL) begin
                        state       <= S_DONE;
                        error       <= 1'b1;
                        result      <= '0;
                        displayBits <= ERR_DISP;
                    end else begin
                        state <= S_CALC;
                        error <= 1'b0;
                    end
                end
                S_CALC: begin
                    acc <= acc_nx;
                    idx <= idx + IDX_W'(1);
                    if (calc_last) begin
                        res_q <= calc_val;
                        neg_q <= calc_val[RES_W];
                        state <= S_CONV;
                    end
                end
                S_CONV: if (!conv_busy) begin
                    state       <= S_DONE;
                    result      <= res_q;
                    displayBits <= disp_nx;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_alu_display.sv
// Directed bench for seq_alu_display: latency, result, display image, error
// flag, ignored restarts and asynchronous abort.
module tb_seq_alu_display;

    logic        clk, rst, start, signed_mode;
    logic [3:0]  op1, op2;
    logic [1:0]  opcode;
    logic        busy, done, error;
    logic [8:0]  result;
    logic [47:0] displayBits;

    int checks = 0;
    int errors = 0;

    seq_alu_display #(.OP_W(4), .NUM_DIGITS(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2),
        .opcode(opcode), .signed_mode(signed_mode), .busy(busy), .done(done),
        .error(error), .result(result), .displayBits(displayBits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns the number of rising edges until done.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] oc,
                          input logic sm, output int n);
        op1 = a; op2 = b; opcode = oc; signed_mode = sm; start = 1'b1;
        @(posedge clk); n = 1;
        @(negedge clk); start = 1'b0;
        while (!done && n < 40) begin
            @(posedge clk); n++;
            @(negedge clk);
        end
    endtask

    task automatic expect_op(input string tag, input int n, input int n_exp,
                             input logic [8:0] r, input logic [47:0] d, input logic e);
        chk({tag, "_lat"},  n, n_exp);
        chk({tag, "_res"},  result, r);
        chk({tag, "_disp"}, displayBits, d);
        chk({tag, "_err"},  error, e);
        @(negedge clk);
        chk({tag, "_pulse"}, {done, busy}, 2'b00);
        chk({tag, "_hold"},  displayBits, d);
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1; start = 1'b0; op1 = '0; op2 = '0; opcode = '0; signed_mode = 1'b0;
        @(negedge clk);
        chk("rst_flags",  {busy, done, error}, 3'b000);
        chk("rst_result", result, 9'd0);
        chk("rst_disp",   displayBits, 48'hFFFF_FFFF_FFFF);
        rst = 1'b0;
        @(negedge clk);

        run_op(4'd9, 4'd7, 2'b00, 1'b0, n);
        expect_op("add_u", n, 10, 9'd16, 48'hFFFF_FFFF_F982, 1'b0);
        run_op(4'd3, 4'd5, 2'b01, 1'b1, n);
        expect_op("sub_s", n, 10, 9'h1FE, 48'hBFFF_FFFF_FFA4, 1'b0);
        run_op(4'd0, 4'd15, 2'b01, 1'b0, n);
        expect_op("sub_u_borrow", n, 10, 9'h1F1, 48'hBFFF_FFFF_F992, 1'b0);
        run_op(4'h8, 4'h8, 2'b00, 1'b1, n);
        expect_op("add_s_min", n, 10, 9'h1F0, 48'hBFFF_FFFF_F982, 1'b0);
        run_op(4'd15, 4'd15, 2'b10, 1'b0, n);
        expect_op("mul_u_max", n, 13, 9'd225, 48'hFFFF_FFA4_A492, 1'b0);
        run_op(4'h8, 4'h8, 2'b10, 1'b1, n);
        expect_op("mul_s_min", n, 13, 9'd64, 48'hFFFF_FFFF_8299, 1'b0);
        run_op(4'hD, 4'd5, 2'b10, 1'b1, n);
        expect_op("mul_s_neg", n, 13, 9'h1F1, 48'hBFFF_FFFF_F992, 1'b0);

        run_op(4'd9, 4'd9, 2'b11, 1'b0, n);
        expect_op("illegal", n, 1, 9'd0, 48'hFFFF_FF86_AFAF, 1'b1);
        chk("err_sticky", error, 1'b1);
        run_op(4'd0, 4'd0, 2'b00, 1'b0, n);
        expect_op("err_clear", n, 10, 9'd0, 48'hFFFF_FFFF_FFC0, 1'b0);

        // restart and operand changes while busy must not disturb 2*3
        op1 = 4'd2; op2 = 4'd3; opcode = 2'b10; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); n = 1;
        @(negedge clk); start = 1'b0;
        repeat (2) begin @(posedge clk); n++; @(negedge clk); end
        start = 1'b1; op1 = 4'd15; op2 = 4'd15; opcode = 2'b00; signed_mode = 1'b1;
        repeat (6) begin @(posedge clk); n++; @(negedge clk); end
        chk("ign_busy", busy, 1'b1);
        start = 1'b0;
        while (!done && n < 40) begin @(posedge clk); n++; @(negedge clk); end
        expect_op("ign_start", n, 13, 9'd6, 48'hFFFF_FFFF_FF82, 1'b0);

        // asynchronous abort during conversion of a multiply
        op1 = 4'd15; op2 = 4'd15; opcode = 2'b10; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (6) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        #1;
        chk("abort_flags",  {busy, done, error}, 3'b000);
        chk("abort_disp",   displayBits, 48'hFFFF_FFFF_FFFF);
        chk("abort_result", result, 9'd0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (15) begin @(negedge clk); if (done) seen++; end
        chk("abort_no_done", seen, 0);
        run_op(4'd9, 4'd7, 2'b00, 1'b0, n);
        expect_op("recover", n, 10, 9'd16, 48'hFFFF_FFFF_F982, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
